// File: rtl/cfg_dispatch_pkg.sv
// rtl/cfg_dispatch_pkg.sv - shared types and helpers for the config-write distributor
// Contents:
//   state_e      dispatcher FSM state (ST_IDLE, ST_ISSUE)
//   CFG_*_W      default field widths of a config write
//   cfg_entry_t  config write {sel, sram_sel, addr, data} at the default widths
//   bcast_sel()  all-ones select value for a given select width
package cfg_dispatch_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  localparam int CFG_SEL_W      = 2;
  localparam int CFG_SRAM_SEL_W = 8;
  localparam int CFG_ADDR_W     = 7;
  localparam int CFG_DATA_W     = 64;

  typedef struct packed {
    logic [CFG_SEL_W-1:0]      sel;
    logic [CFG_SRAM_SEL_W-1:0] sram_sel;
    logic [CFG_ADDR_W-1:0]     addr;
    logic [CFG_DATA_W-1:0]     data;
  } cfg_entry_t;

  function automatic int unsigned bcast_sel(input int unsigned sel_w);
    return (32'd1 << sel_w) - 32'd1;
  endfunction

endpackage

// File: rtl/cfg_sync_fifo.sv
// rtl/cfg_sync_fifo.sv - generic synchronous FIFO with registered full/empty flags
// Parameters: WIDTH entry width, DEPTH entries (power of two, >= 2)
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset (flushes contents)
//   push_i    in   write wdata_i when not full
//   wdata_i   in   WIDTH  entry to write
//   pop_i     in   remove head when not empty
//   rdata_o   out  WIDTH  current head entry
//   full_o    out  registered full flag
//   empty_o   out  registered empty flag
module cfg_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             full_q;
  logic             empty_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;
  // Simultaneous push and pop leaves the occupancy unchanged.
  assign count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);

  // Pointers are AW bits wide, so they wrap modulo DEPTH by themselves.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == (AW+1)'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/cfg_dispatch.sv
// rtl/cfg_dispatch.sv - config-write distributor from one config port to NUM_TGT targets
// Optional feature macro: CFG_BCAST_EN (all-ones select broadcasts to every target)
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   i_cfg_valid        config write offered
//   o_cfg_ready        input FIFO not full; transfer on valid & ready
//   i_cfg_sel_module   target index
//   i_cfg_sram_sel     SRAM select within target
//   i_cfg_addr_write   SRAM write address
//   i_cfg_data         write data
//   o_tgt_wr_en        one-hot (all-ones on broadcast) target write enable
//   i_tgt_ready        per-target accept; a bit completes on wr_en[k] & ready[k]
//   o_tgt_sram_sel     shared SRAM select (0 while no write enable)
//   o_tgt_addr_write   shared address (0 while no write enable)
//   o_tgt_data         shared data (0 while no write enable)
//   o_busy             FIFO non-empty or write outstanding
//   o_err_cnt          saturating count of dropped invalid-select writes
module cfg_dispatch
  import cfg_dispatch_pkg::*;
#(
  parameter int NUM_TGT    = 4,
  parameter int SEL_W      = 2,
  parameter int SRAM_SEL_W = 8,
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cfg_valid,
  output logic                  o_cfg_ready,
  input  logic [SEL_W-1:0]      i_cfg_sel_module,
  input  logic [SRAM_SEL_W-1:0] i_cfg_sram_sel,
  input  logic [ADDR_W-1:0]     i_cfg_addr_write,
  input  logic [DATA_W-1:0]     i_cfg_data,
  output logic [NUM_TGT-1:0]    o_tgt_wr_en,
  input  logic [NUM_TGT-1:0]    i_tgt_ready,
  output logic [SRAM_SEL_W-1:0] o_tgt_sram_sel,
  output logic [ADDR_W-1:0]     o_tgt_addr_write,
  output logic [DATA_W-1:0]     o_tgt_data,
  output logic                  o_busy,
  output logic [ERR_W-1:0]      o_err_cnt
);

  typedef struct packed {
    logic [SEL_W-1:0]      sel;
    logic [SRAM_SEL_W-1:0] sram_sel;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     data;
  } entry_t;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  entry_t                  in_entry;
  entry_t                  head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    fifo_push;
  logic                    fifo_pop;

  state_e                  state_q;
  logic [NUM_TGT-1:0]      wr_en_q;
  logic [NUM_TGT-1:0]      wr_en_d;
  logic [SRAM_SEL_W-1:0]   sram_sel_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       data_q;
  logic [ERR_W-1:0]        err_cnt_q;

  logic                    sel_valid;
  logic                    sel_bcast;
  logic [NUM_TGT-1:0]      sel_onehot;

  assign in_entry = '{sel:      i_cfg_sel_module,
                      sram_sel: i_cfg_sram_sel,
                      addr:     i_cfg_addr_write,
                      data:     i_cfg_data};

  assign fifo_push = i_cfg_valid & ~fifo_full;
  // The head is consumed in IDLE whether it is issued or dropped.
  assign fifo_pop  = (state_q == ST_IDLE) & ~fifo_empty;

  cfg_sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i (in_entry),
    .pop_i   (fifo_pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign sel_valid  = (32'(head.sel) < 32'(NUM_TGT));
  assign sel_onehot = NUM_TGT'(1) << head.sel;

`ifdef CFG_BCAST_EN
  localparam logic [SEL_W-1:0] BCAST_SEL = SEL_W'(bcast_sel(SEL_W));
  assign sel_bcast = (head.sel == BCAST_SEL);
`else
  assign sel_bcast = 1'b0;
`endif

  // Each outstanding enable bit retires independently on its own ready.
  assign wr_en_d = wr_en_q & ~i_tgt_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_en_q    <= '0;
      sram_sel_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      err_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            if (sel_bcast || sel_valid) begin
              wr_en_q    <= sel_bcast ? {NUM_TGT{1'b1}} : sel_onehot;
              sram_sel_q <= head.sram_sel;
              addr_q     <= head.addr;
              data_q     <= head.data;
              state_q    <= ST_ISSUE;
            end else if (err_cnt_q != ERR_MAX) begin
              err_cnt_q <= err_cnt_q + ERR_W'(1);
            end
          end
        end
        ST_ISSUE: begin
          wr_en_q <= wr_en_d;
          if (wr_en_d == '0) begin
            sram_sel_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          wr_en_q <= '0;
        end
      endcase
    end
  end

  assign o_cfg_ready      = ~fifo_full;
  assign o_tgt_wr_en      = wr_en_q;
  assign o_tgt_sram_sel   = sram_sel_q;
  assign o_tgt_addr_write = addr_q;
  assign o_tgt_data       = data_q;
  assign o_busy           = ~fifo_empty | (state_q == ST_ISSUE);
  assign o_err_cnt        = err_cnt_q;

endmodule

// File: tb/tb_cfg_dispatch.sv
// tb/tb_cfg_dispatch.sv - directed self-checking bench for cfg_dispatch
module tb_cfg_dispatch;
  import cfg_dispatch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: four targets.
  logic        a_valid, a_ready, a_busy;
  logic [1:0]  a_sel;
  logic [7:0]  a_sram, a_o_sram;
  logic [6:0]  a_addr, a_o_addr;
  logic [63:0] a_data, a_o_data;
  logic [3:0]  a_wr_en, a_tready;
  logic [7:0]  a_err;

  // Instance B: three targets, so select 3 is out of range (or broadcast).
  logic        b_valid, b_ready, b_busy;
  logic [1:0]  b_sel;
  logic [7:0]  b_sram, b_o_sram;
  logic [6:0]  b_addr, b_o_addr;
  logic [63:0] b_data, b_o_data;
  logic [2:0]  b_wr_en, b_tready;
  logic [7:0]  b_err;

  int n_checks = 0;
  int n_fail   = 0;

  cfg_dispatch #(.NUM_TGT(4), .SEL_W(2), .SRAM_SEL_W(8), .ADDR_W(7), .DATA_W(64),
                 .FIFO_DEPTH(4), .ERR_W(8)) dut_a (
    .clk(clk), .rst(rst),
    .i_cfg_valid(a_valid), .o_cfg_ready(a_ready),
    .i_cfg_sel_module(a_sel), .i_cfg_sram_sel(a_sram),
    .i_cfg_addr_write(a_addr), .i_cfg_data(a_data),
    .o_tgt_wr_en(a_wr_en), .i_tgt_ready(a_tready),
    .o_tgt_sram_sel(a_o_sram), .o_tgt_addr_write(a_o_addr), .o_tgt_data(a_o_data),
    .o_busy(a_busy), .o_err_cnt(a_err)
  );

  cfg_dispatch #(.NUM_TGT(3), .SEL_W(2), .SRAM_SEL_W(8), .ADDR_W(7), .DATA_W(64),
                 .FIFO_DEPTH(4), .ERR_W(8)) dut_b (
    .clk(clk), .rst(rst),
    .i_cfg_valid(b_valid), .o_cfg_ready(b_ready),
    .i_cfg_sel_module(b_sel), .i_cfg_sram_sel(b_sram),
    .i_cfg_addr_write(b_addr), .i_cfg_data(b_data),
    .o_tgt_wr_en(b_wr_en), .i_tgt_ready(b_tready),
    .o_tgt_sram_sel(b_o_sram), .o_tgt_addr_write(b_o_addr), .o_tgt_data(b_o_data),
    .o_busy(b_busy), .o_err_cnt(b_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input cfg_entry_t e);
    a_valid = 1'b1;
    a_sel = e.sel; a_sram = e.sram_sel; a_addr = e.addr; a_data = e.data;
    tick();
    a_valid = 1'b0;
  endtask

  task automatic push_b(input cfg_entry_t e);
    b_valid = 1'b1;
    b_sel = e.sel; b_sram = e.sram_sel; b_addr = e.addr; b_data = e.data;
    tick();
    b_valid = 1'b0;
  endtask

  cfg_entry_t e;
  cfg_entry_t q3 [5];
  int pushed;

  initial begin
    a_valid = 1'b0; a_sel = '0; a_sram = '0; a_addr = '0; a_data = '0; a_tready = 4'b1111;
    b_valid = 1'b0; b_sel = '0; b_sram = '0; b_addr = '0; b_data = '0; b_tready = 3'b111;

    // Reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_ready",  a_ready, 1);
    check("rst_wr_en",  a_wr_en, 0);
    check("rst_data",   a_o_data, 0);
    check("rst_busy",   a_busy, 0);
    check("rst_err",    a_err, 0);

    // 1: single write, ready already high -> one-beat enable two cycles after acceptance
    e = '{sel: 2'd2, sram_sel: 8'h3C, addr: 7'h15, data: 64'hDEAD_BEEF};
    push_a(e);
    check("t1_wr_en_n1", a_wr_en, 4'b0000);
    check("t1_busy_n1",  a_busy, 1);
    tick();
    check("t1_wr_en",    a_wr_en, 4'b0100);
    check("t1_sram",     a_o_sram, 8'h3C);
    check("t1_addr",     a_o_addr, 7'h15);
    check("t1_data",     a_o_data, 64'hDEAD_BEEF);
    tick();
    check("t1_wr_en_after", a_wr_en, 4'b0000);
    check("t1_data_after",  a_o_data, 0);
    check("t1_addr_after",  a_o_addr, 0);
    check("t1_busy_after",  a_busy, 0);

    // 2: target 1 stalls for 5 cycles
    a_tready = 4'b1101;
    e = '{sel: 2'd1, sram_sel: 8'h5A, addr: 7'h2A, data: 64'h1234_5678_9ABC_DEF0};
    push_a(e);
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_wr_en_hold%0d", i), a_wr_en, 4'b0010);
      check($sformatf("t2_data_hold%0d", i),  a_o_data, 64'h1234_5678_9ABC_DEF0);
      tick();
    end
    a_tready = 4'b1111;
    check("t2_wr_en_ready_cycle", a_wr_en, 4'b0010);
    tick();
    check("t2_wr_en_cleared", a_wr_en, 4'b0000);
    check("t2_sram_cleared",  a_o_sram, 0);

    // 3: back-pressure with five writes into a 4-deep FIFO, then ordered drain
    a_tready = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      q3[k] = '{sel: 2'(k % 4), sram_sel: 8'(8'h10 + k), addr: 7'(k), data: 64'(64'h100 + k)};
      check($sformatf("t3_ready_before%0d", k), a_ready, 1);
      push_a(q3[k]);
    end
    check("t3_ready_full", a_ready, 0);
    a_valid = 1'b1;
    a_sel = 2'd3; a_sram = 8'hEE; a_addr = 7'h7F; a_data = 64'hBAD;
    tick();
    a_valid = 1'b0;
    check("t3_ready_still_full", a_ready, 0);
    check("t3_head_issue", a_wr_en, 4'b0001);
    a_tready = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t3_order_wr_en%0d", k), a_wr_en, 4'(4'b0001 << (k % 4)));
      check($sformatf("t3_order_data%0d", k),  a_o_data, 64'h100 + 64'(k));
      check($sformatf("t3_order_addr%0d", k),  a_o_addr, 7'(k));
      tick();
      check($sformatf("t3_gap%0d", k), a_wr_en, 4'b0000);
      tick();
    end
    check("t3_drained_busy",  a_busy, 0);
    check("t3_drained_ready", a_ready, 1);
    check("t3_no_err",        a_err, 0);

`ifndef CFG_BCAST_EN
    // 4: out-of-range select is dropped and counted, counter saturates
    e = '{sel: 2'd3, sram_sel: 8'h01, addr: 7'h01, data: 64'h1};
    push_b(e);
    check("t4_err_before", b_err, 0);
    tick();
    check("t4_wr_en", b_wr_en, 3'b000);
    check("t4_err_one", b_err, 1);
    check("t4_data_zero", b_o_data, 0);
    pushed = 1;
    b_valid = 1'b1;
    for (int g = 0; g < 1000 && pushed < 300; g++) begin
      if (b_ready) pushed++;
      tick();
      check("t4_wr_en_idle", b_wr_en, 3'b000);
    end
    b_valid = 1'b0;
    check("t4_pushed", pushed, 300);
    repeat (6) tick();
    check("t4_err_sat", b_err, 255);
    check("t4_busy", b_busy, 0);
`else
    // 5: broadcast with staggered target readiness
    b_tready = 3'b000;
    e = '{sel: 2'd3, sram_sel: 8'hA5, addr: 7'h33, data: 64'hCAFE};
    push_b(e);
    tick();
    check("t5_wr_en_111", b_wr_en, 3'b111);
    check("t5_data", b_o_data, 64'hCAFE);
    b_tready = 3'b001;
    tick();
    check("t5_wr_en_110", b_wr_en, 3'b110);
    b_tready = 3'b100;
    tick();
    check("t5_wr_en_010", b_wr_en, 3'b010);
    b_tready = 3'b010;
    tick();
    check("t5_wr_en_000", b_wr_en, 3'b000);
    check("t5_data_zero", b_o_data, 0);
    b_tready = 3'b111;
    tick();
    check("t5_no_reissue", b_wr_en, 3'b000);
    check("t5_busy", b_busy, 0);
    check("t5_err", b_err, 0);
`endif

    // 6: reset during an outstanding write with two entries queued
    a_tready = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      e = '{sel: 2'(k), sram_sel: 8'h77, addr: 7'(7'h40 + k), data: 64'(64'hF00 + k)};
      push_a(e);
    end
    check("t6_issue_pending", a_wr_en, 4'b0001);
    check("t6_busy_pending",  a_busy, 1);
    rst = 1'b1;
    tick();
    check("t6_rst_wr_en", a_wr_en, 0);
    check("t6_rst_data",  a_o_data, 0);
    check("t6_rst_busy",  a_busy, 0);
    check("t6_rst_err",   a_err, 0);
    check("t6_rst_err_b", b_err, 0);
    rst = 1'b0;
    a_tready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t6_no_stale%0d", i), a_wr_en, 0);
      check($sformatf("t6_idle_busy%0d", i), a_busy, 0);
    end
    check("t6_ready", a_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
